// File: rtl/sched_dp_pkg.sv
// Shared types, op codes and microinstruction field layout for the sched_dp datapath.
// Field positions depend only on the register count, so they are plain functions of nregs.
package sched_dp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_SHL    = 4'd5;
    localparam logic [3:0] OP_SHR    = 4'd6;
    localparam logic [3:0] OP_PASS_A = 4'd7;
    localparam logic [3:0] OP_PASS_B = 4'd8;
    localparam logic [3:0] OP_UMAX   = 4'd9;
    localparam logic [3:0] OP_UMIN   = 4'd10;

    localparam int FLD_LAST   = 0;
    localparam int FLD_OUT_EN = 1;
    localparam int FLD_B1_SRC = 2;
    localparam int FLD_B2_SRC = 3;
    localparam int FLD_REG_EN = 4;

    // F2 only has four ops; they reuse the F1 op table.
    function automatic logic [3:0] f2_to_f1_op(input logic [1:0] op);
        logic [3:0] f;
        f = OP_ADD;
        case (op)
            2'd0: f = OP_ADD;
            2'd1: f = OP_SUB;
            2'd2: f = OP_UMAX;
            2'd3: f = OP_UMIN;
        endcase
        return f;
    endfunction

    function automatic int sel_w(input int nregs);
        return $clog2(nregs);
    endfunction

    function automatic int reg_sel_lo(input int nregs);
        return 4 + nregs;
    endfunction

    function automatic int f1_op_lo(input int nregs);
        return 4 + 2 * nregs;
    endfunction

    function automatic int f2_op_lo(input int nregs);
        return 8 + 2 * nregs;
    endfunction

    function automatic int f1_a_lo(input int nregs);
        return 10 + 2 * nregs;
    endfunction

    function automatic int f1_b_lo(input int nregs);
        return f1_a_lo(nregs) + sel_w(nregs);
    endfunction

    function automatic int f2_a_lo(input int nregs);
        return f1_a_lo(nregs) + 2 * sel_w(nregs);
    endfunction

    function automatic int f2_b_lo(input int nregs);
        return f1_a_lo(nregs) + 3 * sel_w(nregs);
    endfunction

    function automatic int iw_of(input int nregs);
        return 10 + 2 * nregs + 4 * sel_w(nregs);
    endfunction

endpackage

// File: rtl/sched_dp_fu.sv
// Combinational function unit: 4-bit op table shared by F1 and F2.
module sched_dp_fu
    import sched_dp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:    y = a + b;
            OP_SUB:    y = a - b;
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_XOR:    y = a ^ b;
            OP_SHL:    y = {a[WIDTH-2:0], 1'b0};
            OP_SHR:    y = {1'b0, a[WIDTH-1:1]};
            OP_PASS_A: y = a;
            OP_PASS_B: y = b;
            OP_UMAX:   y = (a > b) ? a : b;
            OP_UMIN:   y = (a < b) ? a : b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/sched_dp.sv
// Self-sequenced two-bus datapath: microprogram memory, register file, pc and FSM.
// state   | meaning
// IDLE    | waiting for start; microprogram may be written
// RUN     | executing one microinstruction per cycle from pc
// DONE    | one-cycle completion pulse, returns to IDLE
module sched_dp
    import sched_dp_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int NREGS      = 4,
    parameter  int PROG_DEPTH = 16,
    localparam int L          = sel_w(NREGS),
    localparam int P          = $clog2(PROG_DEPTH),
    localparam int IW         = iw_of(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_we,
    input  logic [P-1:0]     prog_addr,
    input  logic [IW-1:0]    prog_data,
    input  logic             start,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    localparam int RS_LO  = reg_sel_lo(NREGS);
    localparam int F1O_LO = f1_op_lo(NREGS);
    localparam int F2O_LO = f2_op_lo(NREGS);
    localparam int F1A_LO = f1_a_lo(NREGS);
    localparam int F1B_LO = f1_b_lo(NREGS);
    localparam int F2A_LO = f2_a_lo(NREGS);
    localparam int F2B_LO = f2_b_lo(NREGS);

    state_t           state;
    logic [P-1:0]     pc;
    logic [IW-1:0]    prog_mem [PROG_DEPTH];
    logic [WIDTH-1:0] regs [NREGS];

    logic [IW-1:0]    uw;
    logic             w_last, w_out_en, w_b1_src, w_b2_src;
    logic [NREGS-1:0] w_reg_en, w_reg_sel;
    logic [3:0]       w_f1_op, f2_op_mapped;
    logic [1:0]       w_f2_op;
    logic [L-1:0]     w_f1_a, w_f1_b, w_f2_a, w_f2_b;
    logic [WIDTH-1:0] f1_y, f2_y, bus1, bus2;

    assign uw        = prog_mem[pc];
    assign w_last    = uw[FLD_LAST];
    assign w_out_en  = uw[FLD_OUT_EN];
    assign w_b1_src  = uw[FLD_B1_SRC];
    assign w_b2_src  = uw[FLD_B2_SRC];
    assign w_reg_en  = uw[FLD_REG_EN +: NREGS];
    assign w_reg_sel = uw[RS_LO +: NREGS];
    assign w_f1_op   = uw[F1O_LO +: 4];
    assign w_f2_op   = uw[F2O_LO +: 2];
    assign w_f1_a    = uw[F1A_LO +: L];
    assign w_f1_b    = uw[F1B_LO +: L];
    assign w_f2_a    = uw[F2A_LO +: L];
    assign w_f2_b    = uw[F2B_LO +: L];

    assign f2_op_mapped = f2_to_f1_op(w_f2_op);

    sched_dp_fu #(.WIDTH(WIDTH)) u_f1 (
        .op (w_f1_op),
        .a  (regs[w_f1_a]),
        .b  (regs[w_f1_b]),
        .y  (f1_y)
    );

    sched_dp_fu #(.WIDTH(WIDTH)) u_f2 (
        .op (f2_op_mapped),
        .a  (regs[w_f2_a]),
        .b  (regs[w_f2_b]),
        .y  (f2_y)
    );

    assign bus1 = w_b1_src ? f1_y : in0;
    assign bus2 = w_b2_src ? f2_y : in1;

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // Program memory has no reset so a loaded schedule survives rst.
    always_ff @(posedge clk) begin
        if (prog_we && state != ST_RUN) begin
            prog_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pc        <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        pc    <= '0;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NREGS; i++) begin
                        if (w_reg_en[i]) begin
                            regs[i] <= w_reg_sel[i] ? bus2 : bus1;
                        end
                    end
                    if (w_out_en) begin
                        out       <= bus1;
                        out_valid <= 1'b1;
                    end
                    // The top word always terminates, so a program without last cannot run away.
                    if (w_last || pc == P'(PROG_DEPTH - 1)) begin
                        state <= ST_DONE;
                        pc    <= '0;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sched_dp.sv
// Directed bench for sched_dp: table of two/three-word programs plus reset and protocol sequences.
module tb_sched_dp;
    import sched_dp_pkg::*;

    localparam int IW = 26;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [3:0]    prog_addr;
    logic [IW-1:0] prog_data;
    logic          start;
    logic [31:0]   in0, in1;
    logic          busy, done, out_valid;
    logic [31:0]   out;

    sched_dp dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .in0       (in0),
        .in1       (in1),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int          r_ncyc, r_nval, r_ndone, r_done_idx, r_val_idx;
    logic [31:0] r_first, r_last;

    typedef struct {
        logic [31:0]   in0;
        logic [31:0]   in1;
        logic [IW-1:0] w1;
        logic [IW-1:0] w2;
        int            nwords;
        logic [31:0]   exp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic last, input logic oe, input logic b1,
                                         input logic b2, input logic [3:0] ren,
                                         input logic [3:0] rsel, input logic [3:0] f1op,
                                         input logic [1:0] f2op, input logic [1:0] f1a,
                                         input logic [1:0] f1b, input logic [1:0] f2a,
                                         input logic [1:0] f2b);
        logic [IW-1:0] w;
        w        = '0;
        w[0]     = last;
        w[1]     = oe;
        w[2]     = b1;
        w[3]     = b2;
        w[7:4]   = ren;
        w[11:8]  = rsel;
        w[15:12] = f1op;
        w[17:16] = f2op;
        w[19:18] = f1a;
        w[21:20] = f1b;
        w[23:22] = f2a;
        w[25:24] = f2b;
        return w;
    endfunction

    function automatic logic [IW-1:0] f1w(input logic [3:0] op, input logic [1:0] a,
                                          input logic [1:0] b);
        return mk(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, op, 2'd0, a, b, 2'd0, 2'd0);
    endfunction

    function automatic logic [IW-1:0] f2w(input logic [1:0] op);
        return mk(1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0001, 4'd0, op, 2'd0, 2'd0, 2'd2, 2'd3);
    endfunction

    task automatic write_word(input logic [3:0] addr, input logic [IW-1:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(posedge clk);
        #1 prog_we = 1'b0;
    endtask

    // Start a run (optionally writing word 0 in the same cycle) and observe a fixed window.
    task automatic run_prog(input logic we, input logic [IW-1:0] wd, input int window);
        r_ncyc = 0; r_nval = 0; r_ndone = 0; r_done_idx = -1; r_val_idx = -1;
        r_first = 'x; r_last = 'x;
        prog_we   = we;
        prog_addr = 4'd0;
        prog_data = wd;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        prog_we = 1'b0;
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            if (busy) r_ncyc++;
            if (out_valid) begin
                if (r_nval == 0) r_first = out;
                r_last    = out;
                r_val_idx = i;
                r_nval++;
            end
            if (done) begin
                r_ndone++;
                r_done_idx = i;
            end
        end
    endtask

    logic [IW-1:0] w_load, w_pass_r0, w_runaway, w_lastw;
    int            ndone_rst, nbusy_after, p_ncyc, p_ndone, p_done_idx;

    initial begin
        w_load    = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'b1010, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        w_pass_r0 = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, OP_PASS_A, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        w_runaway = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'b1010, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        w_lastw   = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);

        vecs[0]  = '{32'd5,        32'd7,        f1w(OP_ADD, 0, 1),    '0, 2, 32'd12};
        vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, f1w(OP_ADD, 0, 1),    '0, 2, 32'hFFFFFFFE};
        vecs[2]  = '{32'd0,        32'd1,        f1w(OP_SUB, 0, 1),    '0, 2, 32'hFFFFFFFF};
        vecs[3]  = '{32'hF0F01234, 32'h0FF00004, f1w(OP_XOR, 0, 1),    '0, 2, 32'hFF001230};
        vecs[4]  = '{32'hFF00FF00, 32'h0F0F0F0F, f1w(OP_AND, 0, 1),    '0, 2, 32'h0F000F00};
        vecs[5]  = '{32'hFF00FF00, 32'h0F0F0F0F, f1w(OP_OR, 0, 1),     '0, 2, 32'hFF0FFF0F};
        vecs[6]  = '{32'h80000001, 32'd0,        f1w(OP_SHL, 0, 1),    '0, 2, 32'h00000002};
        vecs[7]  = '{32'h80000001, 32'd0,        f1w(OP_SHR, 0, 1),    '0, 2, 32'h40000000};
        vecs[8]  = '{32'd5,        32'hDEADBEEF, f1w(OP_PASS_B, 0, 1), '0, 2, 32'hDEADBEEF};
        vecs[9]  = '{32'd5,        32'd7,        f1w(4'd12, 0, 1),     '0, 2, 32'd0};
        vecs[10] = '{32'd3,        32'h80000000, f1w(OP_UMAX, 0, 1),   '0, 2, 32'h80000000};
        vecs[11] = '{32'd3,        32'h80000000, f1w(OP_UMIN, 0, 1),   '0, 2, 32'd3};
        vecs[12] = '{32'h80000000, 32'd3,        f2w(2'd2), w_pass_r0, 3, 32'h80000000};
        vecs[13] = '{32'h80000000, 32'd3,        f2w(2'd3), w_pass_r0, 3, 32'd3};
        vecs[14] = '{32'h80000000, 32'd3,        f2w(2'd0), w_pass_r0, 3, 32'h80000003};
        vecs[15] = '{32'h80000000, 32'd3,        f2w(2'd1), w_pass_r0, 3, 32'h7FFFFFFD};

        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
        in0 = '0; in1 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset out", out, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);

        for (int v = 0; v < 16; v++) begin
            write_word(4'd0, w_load);
            write_word(4'd1, vecs[v].w1);
            if (vecs[v].nwords == 3) write_word(4'd2, vecs[v].w2);
            in0 = vecs[v].in0;
            in1 = vecs[v].in1;
            run_prog(1'b0, '0, 8);
            chk($sformatf("vec%0d out", v), r_last, vecs[v].exp);
            chk($sformatf("vec%0d run cycles", v), r_ncyc, vecs[v].nwords);
            chk($sformatf("vec%0d valid count", v), r_nval, 32'd1);
            chk($sformatf("vec%0d valid time", v), r_val_idx, vecs[v].nwords);
            chk($sformatf("vec%0d done count", v), r_ndone, 32'd1);
            chk($sformatf("vec%0d done time", v), r_done_idx, vecs[v].nwords);
        end

        // Mid-run reset with a program that has no last bit.
        for (int a = 0; a < 16; a++) write_word(4'(a), w_runaway);
        in0 = 32'h11111111;
        in1 = 32'h22222222;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        ndone_rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) ndone_rst++;
            if (i == 1) begin
                chk("midrun rst busy", {31'd0, busy}, 32'd0);
                chk("midrun rst out", out, 32'd0);
                chk("midrun rst out_valid", {31'd0, out_valid}, 32'd0);
                rst = 1'b0;
            end
        end
        chk("midrun rst no done", ndone_rst, 32'd0);

        write_word(4'd0, mk(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, OP_OR, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0));
        write_word(4'd1, mk(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, OP_OR, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0));
        run_prog(1'b0, '0, 6);
        chk("regs cleared r0|r1", r_first, 32'd0);
        chk("regs cleared r2|r3", r_last, 32'd0);
        chk("regs cleared valid count", r_nval, 32'd2);

        // Runaway: words 2..15 survived reset; restore 0..1.
        write_word(4'd0, w_runaway);
        write_word(4'd1, w_runaway);
        run_prog(1'b0, '0, 20);
        chk("runaway run cycles", r_ncyc, 32'd16);
        chk("runaway valid count", r_nval, 32'd16);
        chk("runaway done count", r_ndone, 32'd1);
        chk("runaway done time", r_done_idx, 32'd16);
        chk("runaway out", r_last, 32'h11111111);

        // prog_we and start during RUN, start during DONE: all ignored.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        p_ncyc = 0; p_ndone = 0; p_done_idx = -1; nbusy_after = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 3) begin
                prog_we = 1'b1; prog_addr = 4'd0; prog_data = w_lastw; start = 1'b1;
            end
            if (i == 5) begin
                prog_we = 1'b0; start = 1'b0;
            end
            if (busy) begin
                p_ncyc++;
                if (p_done_idx >= 0) nbusy_after++;
            end
            if (done) begin
                p_ndone++;
                p_done_idx = i;
                start = 1'b1;
            end else if (p_done_idx >= 0) begin
                start = 1'b0;
            end
        end
        chk("protocol run cycles", p_ncyc, 32'd16);
        chk("protocol done count", p_ndone, 32'd1);
        chk("protocol start in DONE ignored", nbusy_after, 32'd0);
        run_prog(1'b0, '0, 20);
        chk("protocol memory unchanged", r_ncyc, 32'd16);

        in0 = 32'h0BADF00D;
        run_prog(1'b1, w_lastw, 6);
        chk("we+start run cycles", r_ncyc, 32'd1);
        chk("we+start out", r_last, 32'h0BADF00D);
        chk("we+start valid count", r_nval, 32'd1);
        chk("we+start done time", r_done_idx, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sched_dp.md
# sched_dp

Parametrised, self-sequenced successor to the three-register two-bus ALAP datapath. It holds NREGS general registers, two shared buses and two function units (F1 and F2). Its control words come from an internal loadable microprogram memory instead of external enable pins. A start/done handshake runs one stored schedule to completion, and the result is emitted on a registered output with a valid strobe. It sits between the FPU operand staging logic and the result collector.

## Interface
- WIDTH, 32, datapath width in bits
- NREGS, 4, number of general registers; power of two, ≥2; L = clog2(NREGS)
- PROG_DEPTH, 16, microprogram words; power of two, ≥2; P = clog2(PROG_DEPTH)
- IW, 10+2·NREGS+4·L (derived, 26 at defaults), microinstruction width
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- prog_we  in  1  write microprogram word; honoured only when busy=0
- prog_addr  in  P  microprogram write address
- prog_data  in  IW  microprogram write data
- start  in  1  begin execution at pc=0; honoured only in IDLE
- in0  in  WIDTH  external operand, bus1 source 0; must be held stable while busy
- in1  in  WIDTH  external operand, bus2 source 0; must be held stable while busy
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse in DONE
- out  out  WIDTH  registered result
- out_valid  out  1  one-cycle pulse when out is updated

## Operation
- Microinstruction fields, LSB first. N=NREGS, base B=10+2N.
  - last[0]; out_en[1]; b1_src[2] (0=in0, 1=F1); b2_src[3] (0=in1, 1=F2)
  - reg_en[4 +: N]; reg_sel[4+N +: N] (per register: 0=bus1, 1=bus2)
  - f1_op[4+2N +: 4]; f2_op[8+2N +: 2]
  - f1_a[B +: L]; f1_b[B+L +: L]; f2_a[B+2L +: L]; f2_b[B+3L +: L]
- Buses are muxes; there are no internal tristates. Each register has one write source per cycle, so write conflicts cannot occur.
- F1 op codes:
  - 0 a+b; 1 a−b; 2 a&b; 3 a|b; 4 a^b
  - 5 a<<1; 6 a>>1 (logical); 7 a; 8 b
  - 9 unsigned max; 10 unsigned min; 11–15 produce 0
- F2 op mapping: 0→add, 1→sub, 2→umax, 3→umin.
- Arithmetic is modulo 2^WIDTH. There are no carry or overflow flags.
- Operands a and b are the registers indexed by the *_a and *_b fields, read combinationally.
- FSM: IDLE → RUN on start; RUN → DONE when the executed word has last=1 or pc=PROG_DEPTH−1; DONE → IDLE unconditionally.
- Any RUN cycle with out_en=1: out ← bus1 and out_valid=1 on the next cycle. This can happen several times per run.
- start while busy or in DONE: ignored.
- prog_we while busy: ignored, and memory is unchanged.
- prog_we together with start in IDLE: the write takes effect first, and the run begins with the new contents.
- Reset values: state IDLE, pc 0, all registers 0, out 0, out_valid 0, busy 0, done 0.
- Microprogram memory is not reset. Its contents survive rst.
- rst mid-run aborts immediately to the reset values. No done pulse is produced.

## Timing
- Start accepted at edge t0: RUN during cycles t0..t0+K−1 for a K-word run, one word per cycle.
- Register writes from word k are visible to word k+1, giving single-cycle latency per schedule step.
- done is high during the cycle after the final RUN cycle. busy is low in that cycle.
- out and out_valid are registered: one cycle after the out_en word.
- Back-to-back runs: the earliest new start is in the IDLE cycle following DONE.
- Program memory write takes one cycle. It is read combinationally at pc.

## Structure
- Package sched_dp_pkg holds:
  - FSM state enum {IDLE, RUN, DONE}
  - F1 op-code constants and the F2→F1 op mapping function
  - field offset/width functions of NREGS
  - the IW function
- Sub-module sched_dp_fu(WIDTH) implements the 4-bit op table. It is instanced twice: F1 directly, F2 through the mapping.
- The register file, microprogram memory, pc and FSM live in the top module.

## Test plan
- Reset: assert rst 2 cycles mid-run -> busy=0, out=0, out_valid=0, registers 0, no done pulse; the reloaded program still runs.
- Load/add: word0 loads r0←in0=5 and r1←in1=7 (bus2); word1 sets F1 add r0,r1, b1_src=1, out_en, last -> out=12, out_valid one cycle after word1, done the cycle after.
- Wrap: in0=in1=0xFFFFFFFF with sub and add -> add gives 0xFFFFFFFE; r0−r1 with r0=0, r1=1 gives 0xFFFFFFFF.
- F2 min/max via bus2: r2=0x80000000, r3=3 -> umax=0x80000000, umin=3 written to r0 through reg_sel=1.
- Runaway: program with no last bit -> exactly PROG_DEPTH RUN cycles, then done.
- Protocol: prog_we and start during RUN ignored (memory readback identical, single done); prog_we+start in IDLE runs the new word0.
